pe_row_feeder: RTL and testbench

Operand feeder and result reader for the 1x2 MAC PE row. It buffers operand beats (a0, a1, b) from an upstream valid/ready stream and drives the row's a0/a1/b0 inputs, delaying a1 by one cycle to match the row's internal b0→b1 register. After a programmed number of beats it flushes the pipeline and returns per-job results on a valid/ready interface. The row's accumulators have no clear, so each result is the accumulator value minus a baseline captured at job start.

---
 rtl/pe_row_feeder.sv | 165 ++++++++++++++++
 tb/tb_pe_row_feeder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_feeder.sv
// pe_row_feeder
//   Operand feeder and result reader for a 1x2 MAC PE row. Operand beats
//   {a0,a1,b} are buffered in a small FIFO and driven to the row's a0/b0
//   inputs, with a1 delayed one cycle to line up with the row's internal
//   b0->b1 register. After len beats the pipeline is flushed and each
//   accumulator's growth since job start is returned as the job result.
// Ports:
//   clk, rst            clock, async active-high reset
//   start, cfg_len      job start pulse (IDLE only) and beat count
//   busy                high whenever a job is in progress
//   in_valid/in_ready   operand beat handshake, in_a0/in_a1/in_b payload
//   a0, a1, b0          registered drive to the PE row
//   c0, c1              PE row accumulator values
//   res_valid/res_ready result handshake, res_c0/res_c1 payload
module pe_row_feeder #(
  parameter int DW    = 16,
  parameter int AW    = 32,
  parameter int DEPTH = 4,
  parameter int KW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] cfg_len,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a0,
  input  logic [DW-1:0] in_a1,
  input  logic [DW-1:0] in_b,
  output logic [DW-1:0] a0,
  output logic [DW-1:0] a1,
  output logic [DW-1:0] b0,
  input  logic [AW-1:0] c0,
  input  logic [AW-1:0] c1,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_c0,
  output logic [AW-1:0] res_c1
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, RESULT} state_t;
  typedef struct packed {
    logic [DW-1:0] a0;
    logic [DW-1:0] a1;
    logic [DW-1:0] b;
  } beat_t;

  state_t        state;
  beat_t         mem [DEPTH];
  beat_t         head;
  logic [PW:0]   wptr, rptr;
  logic          empty, full, push, pop;
  logic [KW-1:0] len, cnt;
  logic [1:0]    fcnt;
  logic [DW-1:0] a1_pend;
  logic [AW-1:0] base0, base1;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty    = (wptr == rptr);
  assign full     = (wptr == {~rptr[PW], rptr[PW-1:0]});
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign pop      = (state == FEED) & ~empty;
  assign head     = mem[rptr[PW-1:0]];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk)
    if (push) mem[wptr[PW-1:0]] <= {in_a0, in_a1, in_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      cnt       <= '0;
      fcnt      <= '0;
      a0        <= '0;
      a1        <= '0;
      b0        <= '0;
      a1_pend   <= '0;
      base0     <= '0;
      base1     <= '0;
      res_c0    <= '0;
      res_c1    <= '0;
      res_valid <= 1'b0;
    end else begin
      // a1 trails a0/b0 by one edge in every state; a1_pend is zero
      // outside FEED/FLUSH so this also holds a1 at zero when idle.
      a1 <= a1_pend;
      case (state)
        IDLE: begin
          a0      <= '0;
          b0      <= '0;
          a1_pend <= '0;
          if (start) begin
            if (cfg_len != '0) begin
              // Row accumulators never clear: remember where they stand.
              len   <= cfg_len;
              cnt   <= '0;
              base0 <= c0;
              base1 <= c1;
              state <= FEED;
            end else begin
              res_c0    <= '0;
              res_c1    <= '0;
              res_valid <= 1'b1;
              state     <= RESULT;
            end
          end
        end
        FEED: begin
          if (pop) begin
            a0      <= head.a0;
            b0      <= head.b;
            a1_pend <= head.a1;
            if (cnt == len - KW'(1)) begin
              cnt   <= '0;
              fcnt  <= '0;
              state <= FLUSH;
            end else begin
              cnt <= cnt + KW'(1);
            end
          end else begin
            // Bubble: zero operands keep the accumulators unchanged.
            a0      <= '0;
            b0      <= '0;
            a1_pend <= '0;
          end
        end
        FLUSH: begin
          // Three cycles: last a1 lands, then PE1 accumulates, then capture.
          a0      <= '0;
          b0      <= '0;
          a1_pend <= '0;
          if (fcnt == 2'd2) begin
            res_c0    <= c0 - base0;
            res_c1    <= c1 - base1;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            fcnt <= fcnt + 2'd1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_row_feeder.sv
// tb_pe_row_feeder
//   Directed bench for pe_row_feeder with a behavioural 1x2 MAC PE row
//   attached. Expected job results are computed from the beats assigned to
//   each job when it is started and checked when the result handshakes.
module tb_pe_row_feeder;
  localparam int DW = 16, AW = 32, DEPTH = 4, KW = 8;

  typedef struct packed {
    logic [DW-1:0] a0;
    logic [DW-1:0] a1;
    logic [DW-1:0] b;
  } beat_t;
  typedef struct packed {
    logic [AW-1:0] c0;
    logic [AW-1:0] c1;
  } res_t;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [KW-1:0] cfg_len = '0;
  logic          busy, in_ready, res_valid;
  logic          in_valid = 1'b0, res_ready = 1'b1;
  logic [DW-1:0] in_a0 = '0, in_a1 = '0, in_b = '0;
  logic [DW-1:0] a0, a1, b0;
  logic [AW-1:0] c0, c1, res_c0, res_c1;

  pe_row_feeder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b(in_b),
    .a0(a0), .a1(a1), .b0(b0), .c0(c0), .c1(c1),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_c0(res_c0), .res_c1(res_c1)
  );

  always #5 clk = ~clk;

  // PE row: PE0 = a0*b0, b passes through a register to PE1 = a1*b1.
  logic [DW-1:0] b1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c0 <= '0;
      c1 <= '0;
      b1 <= '0;
    end else begin
      c0 <= c0 + AW'(a0) * AW'(b0);
      b1 <= b0;
      c1 <= c1 + AW'(a1) * AW'(b1);
    end
  end

  beat_t         drv_q[$];   // beats still to be offered on the input
  beat_t         plan_q[$];  // beats not yet assigned to a job, FIFO order
  res_t          sb[$];      // expected results, oldest first
  logic [DW-1:0] seen_q[$];  // nonzero a0 values observed while monitoring
  int            pass_cnt = 0, total = 0, fail_cnt = 0;
  int            gap_left = 0, bubble_bad = 0;
  bit            gap_en = 1'b0, mon_en = 1'b0;
  logic [AW-1:0] last_c0 = '0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, observe, then return 1ns after posedge.
  task automatic tick();
    bit   took;
    res_t e;
    @(negedge clk);
    if (gap_left > 0) begin
      in_valid = 1'b0;
      gap_left--;
    end else if (drv_q.size() != 0) begin
      in_valid = 1'b1;
      {in_a0, in_a1, in_b} = drv_q[0];
    end else begin
      in_valid = 1'b0;
    end
    took = in_valid && in_ready;
    if (mon_en) begin
      if (a0 != '0) seen_q.push_back(a0);
      else if (b0 != '0) bubble_bad++;
    end
    if (res_valid && res_ready) begin
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_c0", res_c0, e.c0);
        chk("res_c1", res_c1, e.c1);
        last_c0 = res_c0;
      end
    end
    @(posedge clk);
    if (took) begin
      drv_q.delete(0);
      if (gap_en) gap_left = $urandom_range(1, 3);
    end
    #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
    drv_q.push_back({x, y, z});
    plan_q.push_back({x, y, z});
  endtask

  task automatic fill();
    int n = 0;
    while (drv_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("fill_done", drv_q.size() == 0, 1);
  endtask

  task automatic start_job(input int len);
    res_t  e = '0;
    beat_t bt;
    for (int i = 0; i < len; i++) begin
      bt = plan_q.pop_front();
      e.c0 += AW'(bt.a0) * AW'(bt.b);
      e.c1 += AW'(bt.a1) * AW'(bt.b);
    end
    sb.push_back(e);
    cfg_len = KW'(len);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("job_done", (sb.size() == 0) && !busy, 1);
  endtask

  initial begin
    logic [AW-1:0] sum_obs;
    logic [63:0]   prod;
    int            rem, n;

    // Reset state
    repeat (3) tick();
    chk("rst_a0", a0, 0);
    chk("rst_a1", a1, 0);
    chk("rst_b0", b0, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_c0", res_c0, 0);
    rst = 1'b0;
    tick();

    // len=1: exact operand and result timing
    push_beat(3, 5, 7);
    fill();
    start_job(1);
    tick();
    chk("t1_a0", a0, 3);
    chk("t1_b0", b0, 7);
    chk("t1_a1_early", a1, 0);
    tick();
    chk("t1_a1_lag", a1, 5);
    chk("t1_a0_clear", a0, 0);
    tick();
    chk("t1_valid_early", res_valid, 0);
    tick();
    chk("t1_valid_at4", res_valid, 1);
    wait_done(10);

    // len=3 preloaded
    push_beat(1, 2, 3); push_beat(4, 5, 6); push_beat(7, 8, 9);
    fill();
    start_job(3);
    wait_done(20);

    // Same beats with gapped input
    gap_en = 1'b1; gap_left = 2; mon_en = 1'b1; bubble_bad = 0;
    seen_q.delete();
    push_beat(1, 2, 3); push_beat(4, 5, 6); push_beat(7, 8, 9);
    start_job(3);
    wait_done(60);
    gap_en = 1'b0; gap_left = 0; mon_en = 1'b0;
    chk("gap_pops", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      chk("gap_a0_0", seen_q[0], 1);
      chk("gap_a0_1", seen_q[1], 4);
      chk("gap_a0_2", seen_q[2], 7);
    end
    chk("gap_bubble_b0", bubble_bad, 0);

    // Second job against a non-zero baseline
    push_beat(2, 3, 4);
    start_job(1);
    wait_done(20);

    // Result back-pressure, start ignored outside IDLE
    res_ready = 1'b0;
    push_beat(9, 10, 11);
    start_job(1);
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      cfg_len = 8'd1;
      start   = 1'b1;
      tick();
      chk("hold_valid", res_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_c0", res_c0, 99);
      chk("hold_c1", res_c1, 110);
    end
    start = 1'b0;
    res_ready = 1'b1;
    wait_done(10);
    tick();
    chk("start_ignored", busy, 0);

    // FIFO full in IDLE, extra beats queued, zero-length job
    push_beat(1, 2, 3); push_beat(2, 3, 4); push_beat(3, 4, 5);
    push_beat(4, 5, 6); push_beat(5, 6, 7);
    repeat (4) tick();
    chk("full_ready", in_ready, 0);
    chk("full_left", drv_q.size(), 1);
    repeat (2) tick();
    chk("full_ready_hold", in_ready, 0);
    start_job(2);
    wait_done(20);
    mon_en = 1'b1;
    seen_q.delete();
    start_job(0);
    wait_done(10);
    mon_en = 1'b0;
    chk("zero_len_no_pop", seen_q.size(), 0);
    start_job(3);
    wait_done(20);

    // Accumulator overflow across many jobs
    sum_obs = '0;
    rem = 70000;
    while (rem > 0) begin
      n = (rem > 255) ? 255 : rem;
      for (int i = 0; i < n; i++) push_beat(16'hFFFF, 16'hFFFF, 16'hFFFF);
      start_job(n);
      wait_done(400);
      sum_obs += last_c0;
      rem -= n;
    end
    prod = 64'd70000 * 64'hFFFE0001;
    chk("ovf_total", sum_obs, prod[31:0]);

    // Reset in the middle of FEED
    push_beat(1, 2, 3); push_beat(4, 5, 6); push_beat(7, 8, 9); push_beat(10, 11, 12);
    fill();
    start_job(4);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_a0", a0, 0);
    chk("mrst_a1", a1, 0);
    chk("mrst_b0", b0, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_res_valid", res_valid, 0);
    sb.delete();
    plan_q.delete();
    drv_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    push_beat(5, 6, 7);
    start_job(1);
    wait_done(20);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
